// File: rtl/iiitb_icg_pkg.sv
// Shared types and helpers for the multi-channel clock-gating controller.
// Channel FSM encoding is fixed because ch_state exposes it directly.
package iiitb_icg_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'b00,
    ST_WAKE = 2'b01,
    ST_ON   = 2'b10,
    ST_IDLE = 2'b11
  } icg_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/iiitb_icg_cell.sv
// Glitch-free clock gate: enable is retimed on the falling edge and ANDed with clk,
// so the enable only moves while clk is low. rst clears the enable asynchronously.
module iiitb_icg_cell (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic gclk
);

  logic en_neg;

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      en_neg <= 1'b0;
    end else begin
      en_neg <= en;
    end
  end

  assign gclk = clk & en_neg;

endmodule

// File: rtl/iiitb_multi_icg.sv
// Multi-channel clock-gating controller: per-channel OFF/WAKE/ON/IDLE FSM plus a gate cell.
// Optional macro ICG_STATS_EN adds stat_clr and per-channel gated_cnt (edges spent in OFF).
module iiitb_multi_icg
  import iiitb_icg_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int IDLE_CYCLES = 8,
  parameter int WAKE_CYCLES = 2,
  parameter int STAT_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH-1:0]        ch_dis,
  output logic [NUM_CH-1:0]        gclk,
  output logic [NUM_CH-1:0]        ch_ack,
  output logic [2*NUM_CH-1:0]      ch_state
`ifdef ICG_STATS_EN
  ,
  input  logic                     stat_clr,
  output logic [STAT_W*NUM_CH-1:0] gated_cnt
`endif
);

  localparam int CW = clog2(max2(IDLE_CYCLES, WAKE_CYCLES) + 1);
  localparam logic [CW-1:0] WAKE_LAST = CW'(WAKE_CYCLES);
  localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  if (NUM_CH < 1 || IDLE_CYCLES < 1 || WAKE_CYCLES < 1 || STAT_W < 1) begin : g_bad_params
    $error("iiitb_multi_icg: NUM_CH, IDLE_CYCLES, WAKE_CYCLES and STAT_W must all be >= 1");
  end

  // Wake/ack handshake: ch_req high (with ch_dis low) starts the clock; ch_ack rises once the
  // clock has run WAKE_CYCLES edges and stays high until the channel returns to OFF.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    icg_state_t    state_q, state_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic [CW-1:0] icnt_q, icnt_d;
    logic          en_q, en_d;
    logic          ack_q, ack_d;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= ST_OFF;
        wcnt_q  <= '0;
        icnt_q  <= '0;
        en_q    <= 1'b0;
        ack_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        wcnt_q  <= wcnt_d;
        icnt_q  <= icnt_d;
        en_q    <= en_d;
        ack_q   <= ack_d;
      end
    end

    always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      icnt_d  = icnt_q;
      if (ch_dis[i]) begin
        state_d = ST_OFF;
        wcnt_d  = '0;
        icnt_d  = '0;
      end else begin
        case (state_q)
          ST_OFF: begin
            if (ch_req[i]) begin
              state_d = ST_WAKE;
              wcnt_d  = CNT_ONE;
            end
          end
          ST_WAKE: begin
            // req is deliberately ignored here: a started wake always completes.
            if (wcnt_q >= WAKE_LAST) begin
              state_d = ST_ON;
              wcnt_d  = '0;
            end else if (wcnt_q != '1) begin
              wcnt_d = wcnt_q + CNT_ONE;
            end
          end
          ST_ON: begin
            if (!ch_req[i]) begin
              if (IDLE_CYCLES == 1) begin
                state_d = ST_OFF;
              end else begin
                state_d = ST_IDLE;
                icnt_d  = CNT_ONE;
              end
            end
          end
          ST_IDLE: begin
            if (ch_req[i]) begin
              state_d = ST_ON;
              icnt_d  = '0;
            end else if (icnt_q >= IDLE_LAST) begin
              state_d = ST_OFF;
              icnt_d  = '0;
            end else if (icnt_q != '1) begin
              icnt_d = icnt_q + CNT_ONE;
            end
          end
          default: begin
            state_d = ST_OFF;
            wcnt_d  = '0;
            icnt_d  = '0;
          end
        endcase
      end
    end

    // Enable and ack are registered from the next state so they change on the same edge.
    always_comb begin
      en_d  = (state_d != ST_OFF);
      ack_d = (state_d == ST_ON) || (state_d == ST_IDLE);
    end

    assign ch_ack[i]          = ack_q;
    assign ch_state[2*i +: 2] = state_q;

    iiitb_icg_cell u_cell (
      .clk  (clk),
      .rst  (rst),
      .en   (en_q),
      .gclk (gclk[i])
    );

`ifdef ICG_STATS_EN
    logic [STAT_W-1:0] gcnt_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        gcnt_q <= '0;
      end else if (stat_clr) begin
        gcnt_q <= '0;
      end else if (state_q == ST_OFF && gcnt_q != '1) begin
        gcnt_q <= gcnt_q + STAT_W'(1);
      end
    end

    assign gated_cnt[STAT_W*i +: STAT_W] = gcnt_q;
`endif
  end

endmodule

// File: tb/tb_iiitb_multi_icg.sv
// Directed bench for iiitb_multi_icg; define ICG_STATS_EN to also exercise the gated counters.
module tb_iiitb_multi_icg;

  localparam int NUM_CH = 4;
  localparam int STAT_W = 4;

  logic                clk;
  logic                rst;
  logic [NUM_CH-1:0]   ch_req;
  logic [NUM_CH-1:0]   ch_dis;
  logic [NUM_CH-1:0]   gclk;
  logic [NUM_CH-1:0]   ch_ack;
  logic [2*NUM_CH-1:0] ch_state;
`ifdef ICG_STATS_EN
  logic                     stat_clr;
  logic [STAT_W*NUM_CH-1:0] gated_cnt;
`endif

  logic [31:0] exp_q[$];
  int errors;
  int checks;
  int rises[NUM_CH];
  logic [NUM_CH-1:0] gclk_prev;

  iiitb_multi_icg #(
    .NUM_CH      (NUM_CH),
    .IDLE_CYCLES (8),
    .WAKE_CYCLES (2),
    .STAT_W      (STAT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ch_req   (ch_req),
    .ch_dis   (ch_dis),
    .gclk     (gclk),
    .ch_ack   (ch_ack),
    .ch_state (ch_state)
`ifdef ICG_STATS_EN
    ,
    .stat_clr  (stat_clr),
    .gated_cnt (gated_cnt)
`endif
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
    $fatal(1, "watchdog expired");
  end

  // count rising edges of every gated clock
  initial gclk_prev = '0;
  always @(gclk) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (gclk[k] && !gclk_prev[k]) rises[k] = rises[k] + 1;
    end
    gclk_prev = gclk;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  // scoreboard
  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks = checks + 1;
    if (exp_q.size() == 0) begin
      errors = errors + 1;
      $error("FAIL %s: observed %0h, expected queue empty", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors = errors + 1;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
      end
    end
  endtask

  initial begin
    int r0;
    int blip;
    errors = 0;
    checks = 0;
    for (int k = 0; k < NUM_CH; k++) rises[k] = 0;
    rst    = 1'b1;
    ch_req = 4'hF;
    ch_dis = 4'h0;
`ifdef ICG_STATS_EN
    stat_clr = 1'b0;
`endif

    // 1: reset held while clk toggles and every channel requests
    for (int n = 0; n < 3; n++) begin
      push(32'h0); push(32'h0); push(32'h0);
      tick();
      check("rst_gclk", 32'(gclk));
      check("rst_ack", 32'(ch_ack));
      check("rst_state", 32'(ch_state));
    end
    push(32'h0);
    check("rst_no_rise", 32'(rises[0] + rises[1] + rises[2] + rises[3]));
    ch_req = 4'h0;
    rst    = 1'b0;
    push(32'h0);
    tick();
    check("release_state", 32'(ch_state));

    // 2: ch0 wake sequence
    ch_req[0] = 1'b1;
    push(32'h01); push(32'h0); push(32'h0);
    tick();
    check("wake_t_state", 32'(ch_state));
    check("wake_t_ack", 32'(ch_ack));
    check("wake_t_gclk", 32'(gclk));
    push(32'h01); push(32'h0); push(32'h1);
    tick();
    check("wake_t1_state", 32'(ch_state));
    check("wake_t1_ack", 32'(ch_ack));
    check("wake_t1_gclk", 32'(gclk));
    push(32'h02); push(32'h1); push(32'h1);
    tick();
    check("wake_t2_state", 32'(ch_state));
    check("wake_t2_ack", 32'(ch_ack));
    check("wake_t2_gclk", 32'(gclk));

    // 3: ch1 short idle blip must not gate; a full idle run must
    ch_req[1] = 1'b1;
    repeat (3) tick();
    push(32'h2);
    check("ch1_on", 32'(ch_state[3:2]));
    blip = $urandom_range(1, 7);
    r0 = rises[1];
    ch_req[1] = 1'b0;
    for (int n = 0; n < blip; n++) begin
      push(32'h3); push(32'h1);
      tick();
      check("blip_state", 32'(ch_state[3:2]));
      check("blip_ack", 32'(ch_ack[1]));
    end
    ch_req[1] = 1'b1;
    push(32'h2); push(32'h1);
    tick();
    check("blip_back_on", 32'(ch_state[3:2]));
    check("blip_back_ack", 32'(ch_ack[1]));
    push(32'(blip + 1));
    check("blip_gclk_rises", 32'(rises[1] - r0));

    r0 = rises[1];
    ch_req[1] = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      push((n == 8) ? 32'h0 : 32'h3);
      push((n == 8) ? 32'h0 : 32'h1);
      tick();
      check("idle_state", 32'(ch_state[3:2]));
      check("idle_ack", 32'(ch_ack[1]));
    end
    push(32'h8);
    check("idle_rises", 32'(rises[1] - r0));
    r0 = rises[1];
    repeat (3) tick();
    push(32'h0); push(32'h0);
    check("off_no_rise", 32'(rises[1] - r0));
    check("off_gclk", 32'(gclk[1]));

    // 4: hard disable on ch2 while requesting
    ch_req[2] = 1'b1;
    repeat (3) tick();
    push(32'h1);
    check("ch2_on_ack", 32'(ch_ack[2]));
    ch_dis[2] = 1'b1;
    push(32'h0); push(32'h0);
    tick();
    check("dis_state", 32'(ch_state[5:4]));
    check("dis_ack", 32'(ch_ack[2]));
    r0 = rises[2];
    push(32'h0); push(32'h0); push(32'h0);
    tick();
    check("dis_hold_state", 32'(ch_state[5:4]));
    check("dis_gclk", 32'(gclk[2]));
    check("dis_no_rise", 32'(rises[2] - r0));
    ch_dis[2] = 1'b0;
    push(32'h1); push(32'h0);
    tick();
    check("undis_wake", 32'(ch_state[5:4]));
    check("undis_ack0", 32'(ch_ack[2]));
    push(32'h0);
    tick();
    check("undis_ack1", 32'(ch_ack[2]));
    push(32'h2); push(32'h1);
    tick();
    check("undis_on", 32'(ch_state[5:4]));
    check("undis_ack2", 32'(ch_ack[2]));

    // 5: async reset during ch3 wake, while clk is high
    ch_req[3] = 1'b1;
    tick();
    tick();
    push(32'h1);
    check("pre_rst_gclk3", 32'(gclk[3]));
    rst = 1'b1;
    #1;
    push(32'h0); push(32'h0); push(32'h0);
    check("async_rst_gclk", 32'(gclk));
    check("async_rst_ack", 32'(ch_ack));
    check("async_rst_state", 32'(ch_state));
    r0 = rises[0] + rises[1] + rises[2] + rises[3];
    repeat (2) tick();
    push(32'h0);
    check("rst_hold_no_rise", 32'((rises[0] + rises[1] + rises[2] + rises[3]) - r0));
    ch_req = 4'h0;
    rst    = 1'b0;
    tick();

`ifdef ICG_STATS_EN
    // 6: gated-cycle counters; every channel is OFF after the reset above
    stat_clr = 1'b1;
    push(32'h0);
    tick();
    check("stat_clr0", 32'(gated_cnt));
    stat_clr = 1'b0;
    repeat (10) tick();
    push(32'd10); push(32'hAAAA);
    check("stat_10", 32'(gated_cnt[3:0]));
    check("stat_10_all", 32'(gated_cnt));
    repeat (10) tick();
    push(32'd15);
    check("stat_sat", 32'(gated_cnt[3:0]));
    stat_clr = 1'b1;
    push(32'h0);
    tick();
    check("stat_clr_off", 32'(gated_cnt));
    stat_clr = 1'b0;
`endif

    push(32'h0);
    check("scoreboard_drained", 32'(exp_q.size() - 1));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
